// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Buffered dual-issue scheduler between fetch and two execute lanes.
//   Fetch packets (two {instr, pc} slots each) are queued. The head packet
//   issues to lane0 (older) and lane1 (younger). A pair is split on a RAW
//   hazard, on two loads/stores, or when the older instruction is a JAL.
//   A JAL that issues discards everything younger and raises a registered
//   one-cycle redirect to its target.
//
//   Ports
//     clk, rst_n               clock (rising edge), synchronous active-low reset
//     in_valid/in_ready        fetch packet handshake
//     in_data                  {instr1, pc1, instr0, pc0}, slot0 in the LSBs (older)
//     in_mask                  per-slot valid (2'b10 is illegal)
//     flush                    discard all queued and pending state
//     out_ready                backend accepts both lanes this cycle
//     out0_* / out1_*          lane0 / lane1 issue (valid, pc, instr)
//     redirect_valid/_pc       one-cycle fetch restart at the JAL target
//
//   Build option
//     SCHED_PERF_CNT_EN : adds perf_dual_cnt / perf_single_cnt, counting
//                         dual- and single-issue handshakes (reset only).
module dual_issue_scheduler #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*(XLEN+32)-1:0] in_data,
  input  logic [1:0]             in_mask,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   out0_valid,
  output logic [XLEN-1:0]        out0_pc,
  output logic [31:0]            out0_instr,
  output logic                   out1_valid,
  output logic [XLEN-1:0]        out1_pc,
  output logic [31:0]            out1_instr,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]            perf_dual_cnt,
  output logic [31:0]            perf_single_cnt
`endif
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int PKT_W = 2 * (XLEN + 32);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [0:0] ST_PAIR   = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic is_jal(input logic [6:0] opc);
    return opc == OPC_JAL;
  endfunction

  function automatic logic is_mem(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  function automatic logic has_rd(input logic [6:0] opc);
    return (opc != OPC_STORE) && (opc != OPC_BRANCH);
  endfunction

  // J-immediate is 21 bits, sign-extended to XLEN; the add wraps mod 2^XLEN.
  function automatic logic [XLEN-1:0] jal_target(input logic [XLEN-1:0] pc,
                                                 input logic [31:12]     ins);
    logic signed [20:0] imm;
    imm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    return pc + XLEN'(imm);
  endfunction

  logic [PKT_W-1:0] q_data [DEPTH];
  logic             q_has1 [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [0:0]       state;
  logic             redir_vld_p1;
  logic [XLEN-1:0]  redir_pc_p1;

  logic [PKT_W-1:0] head_data;
  logic [XLEN-1:0]  pc0, pc1, a_pc;
  logic [31:0]      instr0, instr1, a_instr;
  logic             empty, b_present, raw, jal_a, dual, split;
  logic             issue_hs, jal_hs, squash, push, pop;

  // Head decode: everything below is combinational from the head entry.
  assign head_data = q_data[head];
  assign pc0       = head_data[XLEN-1:0];
  assign instr0    = head_data[XLEN+31:XLEN];
  assign pc1       = head_data[2*XLEN+31:XLEN+32];
  assign instr1    = head_data[PKT_W-1:2*XLEN+32];

  assign empty     = (count == '0);
  assign a_pc      = (state == ST_PAIR) ? pc0 : pc1;
  assign a_instr   = (state == ST_PAIR) ? instr0 : instr1;
  assign b_present = (state == ST_PAIR) && q_has1[head];
  assign jal_a     = is_jal(a_instr[6:0]);

  assign raw = has_rd(a_instr[6:0]) && (a_instr[11:7] != 5'd0) &&
               ((instr1[19:15] == a_instr[11:7]) || (instr1[24:20] == a_instr[11:7]));

  assign dual  = !empty && b_present && !jal_a &&
                 !(is_mem(a_instr[6:0]) && is_mem(instr1[6:0])) && !raw;
  assign split = b_present && !dual;

  assign out0_valid = !empty;
  assign out0_pc    = empty ? '0 : a_pc;
  assign out0_instr = empty ? '0 : a_instr;
  assign out1_valid = dual;
  assign out1_pc    = dual ? pc1 : '0;
  assign out1_instr = dual ? instr1 : '0;

  assign issue_hs = out0_valid && out_ready;
  assign jal_hs   = issue_hs && (jal_a || (dual && is_jal(instr1[6:0])));
  assign pop      = issue_hs && !split;

  // Squash covers the JAL cycle and the redirect cycle; packets accepted
  // then are absorbed so fetch never stalls on a dead path.
  assign squash   = jal_hs || redir_vld_p1;
  assign in_ready = (count < DEPTH_C) || squash;
  assign push     = in_valid && in_ready && !flush && !squash && (in_mask != 2'b00);

  assign redirect_valid = redir_vld_p1;
  assign redirect_pc    = redir_vld_p1 ? redir_pc_p1 : '0;

  // Control state: pointers, occupancy, head FSM, redirect pulse.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= ST_PAIR;
      redir_vld_p1 <= 1'b0;
    end else if (jal_hs) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= ST_PAIR;
      redir_vld_p1 <= 1'b1;
    end else begin
      redir_vld_p1 <= 1'b0;
      if (push)
        tail <= tail + PW'(1);
      if (issue_hs) begin
        if (split) begin
          state <= ST_SECOND;
        end else begin
          state <= ST_PAIR;
          head  <= head + PW'(1);
        end
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Data storage and redirect target (registered into the redirect cycle).
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= in_data;
      q_has1[tail] <= in_mask[1];
    end
    if (jal_hs)
      redir_pc_p1 <= jal_a ? jal_target(a_pc, a_instr[31:12])
                           : jal_target(pc1, instr1[31:12]);
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_dual_cnt   <= '0;
      perf_single_cnt <= '0;
    end else if (issue_hs) begin
      if (dual)
        perf_dual_cnt <= perf_dual_cnt + 32'd1;
      else
        perf_single_cnt <= perf_single_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
`timescale 1ns/1ps
module tb_dual_issue_scheduler;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  localparam logic [31:0] ADDI1 = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] ADDI2 = 32'h00200113;  // addi x2,x0,2
  localparam logic [31:0] ADD3  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] SUB4  = 32'h40118233;  // sub  x4,x3,x1
  localparam logic [31:0] LW5   = 32'h00032283;  // lw   x5,0(x6)
  localparam logic [31:0] SW5   = 32'h00532023;  // sw   x5,0(x6)
  localparam logic [31:0] ADD7  = 32'h005283B3;  // add  x7,x5,x5
  localparam logic [31:0] JAL20 = 32'h020000EF;  // jal  x1,+0x20

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, flush, out_ready;
  logic [2*(XLEN+32)-1:0] in_data;
  logic [1:0] in_mask;
  logic out0_valid, out1_valid, redirect_valid;
  logic [XLEN-1:0] out0_pc, out1_pc, redirect_pc;
  logic [31:0] out0_instr, out1_instr;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_dual_cnt, perf_single_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dual_issue_scheduler #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .flush(flush), .out_ready(out_ready),
    .out0_valid(out0_valid), .out0_pc(out0_pc), .out0_instr(out0_instr),
    .out1_valid(out1_valid), .out1_pc(out1_pc), .out1_instr(out1_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef SCHED_PERF_CNT_EN
    , .perf_dual_cnt(perf_dual_cnt), .perf_single_cnt(perf_single_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic fl, input logic ordy,
                       input logic [1:0] m, input logic [31:0] i0, input logic [31:0] pc0,
                       input logic [31:0] i1, input logic [31:0] pc1);
    rst_n = r; in_valid = iv; flush = fl; out_ready = ordy; in_mask = m;
    in_data = {i1, pc1, i0, pc0};
  endtask

  task automatic cmp_outs(input string tag, input logic inr, input logic o0v,
                          input logic [31:0] o0pc, input logic [31:0] o0i, input logic o1v,
                          input logic [31:0] o1pc, input logic [31:0] o1i, input logic rv,
                          input logic [31:0] rpc);
    chk({tag, ".in_ready"},   32'(in_ready),       32'(inr));
    chk({tag, ".out0_valid"}, 32'(out0_valid),     32'(o0v));
    chk({tag, ".out0_pc"},    out0_pc,             o0pc);
    chk({tag, ".out0_instr"}, out0_instr,          o0i);
    chk({tag, ".out1_valid"}, 32'(out1_valid),     32'(o1v));
    chk({tag, ".out1_pc"},    out1_pc,             o1pc);
    chk({tag, ".out1_instr"}, out1_instr,          o1i);
    chk({tag, ".redir_vld"},  32'(redirect_valid), 32'(rv));
    chk({tag, ".redir_pc"},   redirect_pc,         rpc);
  endtask

  // Directed vectors: one record per cycle, inputs then expected outputs.
  typedef struct {
    bit chk;
    logic rst_n, iv, fl, ordy;
    logic [1:0] mask;
    logic [31:0] i0, pc0, i1, pc1;
    logic inr, o0v;
    logic [31:0] o0pc, o0i;
    logic o1v;
    logic [31:0] o1pc, o1i;
    logic rv;
    logic [31:0] rpc;
  } vec_t;

  function automatic vec_t mk(bit c, logic r, logic iv, logic fl, logic ordy, logic [1:0] m,
                              logic [31:0] i0, logic [31:0] pc0, logic [31:0] i1, logic [31:0] pc1,
                              logic inr, logic o0v, logic [31:0] o0pc, logic [31:0] o0i,
                              logic o1v, logic [31:0] o1pc, logic [31:0] o1i,
                              logic rv, logic [31:0] rpc);
    vec_t v;
    v.chk = c; v.rst_n = r; v.iv = iv; v.fl = fl; v.ordy = ordy; v.mask = m;
    v.i0 = i0; v.pc0 = pc0; v.i1 = i1; v.pc1 = pc1;
    v.inr = inr; v.o0v = o0v; v.o0pc = o0pc; v.o0i = o0i;
    v.o1v = o1v; v.o1pc = o1pc; v.o1i = o1i; v.rv = rv; v.rpc = rpc;
    return v;
  endfunction

  // Reference model: a queue of packets plus "second slot" and redirect flags.
  typedef struct {
    logic [31:0] i0, pc0, i1, pc1;
    logic [1:0]  mask;
  } pkt_t;

  pkt_t mq[$];
  bit m_second, m_redir;
  logic [31:0] m_rpc;
  int unsigned m_dual, m_single;

  logic e_inr, e_o0v, e_o1v, e_rv;
  logic [31:0] e_o0pc, e_o0i, e_o1pc, e_o1i, e_rpc, e_tgt;
  bit e_hs, e_jal, e_split, e_push, e_dual;

  function automatic bit m_is_jal(logic [31:0] i);
    return i[6:0] == 7'h6F;
  endfunction
  function automatic bit m_is_mem(logic [31:0] i);
    return i[6:0] == 7'h03 || i[6:0] == 7'h23;
  endfunction
  function automatic bit m_writes(logic [31:0] i);
    return i[6:0] != 7'h23 && i[6:0] != 7'h63 && i[11:7] != 5'd0;
  endfunction
  function automatic logic [31:0] m_target(logic [31:0] pc, logic [31:0] i);
    int off;
    off = (int'(i[31]) << 20) + (int'(i[19:12]) << 12) + (int'(i[20]) << 11) + (int'(i[30:21]) << 1);
    if (i[31]) off = off - (1 << 21);
    return pc + off;
  endfunction

  task automatic model_eval();
    pkt_t h;
    logic [31:0] a_i, a_pc;
    bit bp, ok;
    e_o0v = 0; e_o0pc = 0; e_o0i = 0; e_o1v = 0; e_o1pc = 0; e_o1i = 0;
    e_hs = 0; e_jal = 0; e_split = 0; e_dual = 0; e_tgt = 0;
    if (mq.size() > 0) begin
      h    = mq[0];
      a_i  = m_second ? h.i1  : h.i0;
      a_pc = m_second ? h.pc1 : h.pc0;
      bp   = !m_second && h.mask[1];
      ok   = bp && !m_is_jal(a_i) && !(m_is_mem(a_i) && m_is_mem(h.i1)) &&
             !(m_writes(a_i) && (h.i1[19:15] == a_i[11:7] || h.i1[24:20] == a_i[11:7]));
      e_o0v = 1; e_o0pc = a_pc; e_o0i = a_i;
      if (ok) begin e_o1v = 1; e_o1pc = h.pc1; e_o1i = h.i1; end
      e_dual  = ok;
      e_hs    = out_ready;
      e_split = bp && !ok;
      if (e_hs && m_is_jal(a_i)) begin
        e_jal = 1; e_tgt = m_target(a_pc, a_i);
      end else if (e_hs && ok && m_is_jal(h.i1)) begin
        e_jal = 1; e_tgt = m_target(h.pc1, h.i1);
      end
    end
    e_rv   = m_redir;
    e_rpc  = m_redir ? m_rpc : 32'h0;
    e_inr  = (mq.size() < DEPTH) || e_jal || m_redir;
    e_push = in_valid && e_inr && !flush && !(e_jal || m_redir) && (in_mask != 2'b00);
  endtask

  task automatic model_step();
    pkt_t p;
    if (!rst_n) begin
      mq.delete(); m_second = 0; m_redir = 0; m_dual = 0; m_single = 0;
    end else begin
      if (e_hs) begin
        if (e_dual) m_dual++; else m_single++;
      end
      if (flush) begin
        mq.delete(); m_second = 0; m_redir = 0;
      end else if (e_jal) begin
        mq.delete(); m_second = 0; m_redir = 1; m_rpc = e_tgt;
      end else begin
        m_redir = 0;
        if (e_hs) begin
          if (e_split) m_second = 1;
          else begin void'(mq.pop_front()); m_second = 0; end
        end
        if (e_push) begin
          p.pc0 = in_data[31:0]; p.i0 = in_data[63:32];
          p.pc1 = in_data[95:64]; p.i1 = in_data[127:96];
          p.mask = in_mask;
          mq.push_back(p);
        end
      end
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h6F;
      default: w[6:0] = 7'h37;
    endcase
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  vec_t tv[$];

  initial begin
    logic [1:0] m;
    logic [31:0] i0, i1, pc0;
    logic r, iv, fl, ordy;
    vec_t v;

    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    tv.push_back(mk(0,0,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // independent pair
    tv.push_back(mk(1,1,1,0,1,2'b11, ADDI1,32'h100,ADDI2,32'h104, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,1,32'h100,ADDI1,1,32'h104,ADDI2,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // RAW split
    tv.push_back(mk(1,1,1,0,1,2'b11, ADD3,32'h300,SUB4,32'h304,   1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,1,32'h300,ADD3,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,1,32'h304,SUB4,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // lw+sw split, sw+add dual
    tv.push_back(mk(1,1,1,0,1,2'b11, LW5,32'h400,SW5,32'h404,     1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,1,32'h400,LW5,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,1,32'h404,SW5,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,1,2'b11, SW5,32'h500,ADD7,32'h504,    1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,1,32'h500,SW5,1,32'h504,ADD7,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // JAL in slot0 with a full queue behind it
    tv.push_back(mk(1,1,1,0,0,2'b11, JAL20,32'h200,ADDI1,32'h204, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h600,ADDI2,32'h604, 1,1,32'h200,JAL20,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h610,ADDI2,32'h614, 1,1,32'h200,JAL20,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h620,ADDI2,32'h624, 1,1,32'h200,JAL20,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,1,2'b11, ADDI1,32'h630,ADDI2,32'h634, 1,1,32'h200,JAL20,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,1,2'b11, ADDI1,32'h640,ADDI2,32'h644, 1,0,0,0,0,0,0,1,32'h220));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // fill to DEPTH with out_ready low, then flush
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h700,ADDI2,32'h704, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h710,ADDI2,32'h714, 1,1,32'h700,ADDI1,1,32'h704,ADDI2,0,0));
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h720,ADDI2,32'h724, 1,1,32'h700,ADDI1,1,32'h704,ADDI2,0,0));
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h730,ADDI2,32'h734, 1,1,32'h700,ADDI1,1,32'h704,ADDI2,0,0));
    tv.push_back(mk(1,1,1,0,0,2'b11, ADDI1,32'h740,ADDI2,32'h744, 0,1,32'h700,ADDI1,1,32'h704,ADDI2,0,0));
    tv.push_back(mk(1,1,0,1,0,2'b00, 0,0,0,0,                    0,1,32'h700,ADDI1,1,32'h704,ADDI2,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // JAL in lane1
    tv.push_back(mk(1,1,1,0,1,2'b11, ADDI1,32'h800,JAL20,32'h804, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,1,32'h800,ADDI1,1,32'h804,JAL20,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,1,32'h824));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // flush in the JAL cycle cancels the redirect
    tv.push_back(mk(1,1,1,0,1,2'b11, JAL20,32'h900,ADDI2,32'h904, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,1,1,2'b00, 0,0,0,0,                    1,1,32'h900,JAL20,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // single-slot packet, then reset mid-operation
    tv.push_back(mk(1,1,1,0,0,2'b01, ADDI1,32'hA00,ADDI2,32'hA04, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,0,2'b00, 0,0,0,0,                    1,1,32'hA00,ADDI1,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,2'b00, 0,0,0,0,                    1,1,32'hA00,ADDI1,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));
    // empty-mask packet is dropped
    tv.push_back(mk(1,1,1,0,1,2'b00, ADDI1,32'hB00,ADDI2,32'hB04, 1,0,0,0,0,0,0,0,0));
    tv.push_back(mk(1,1,0,0,1,2'b00, 0,0,0,0,                    1,0,0,0,0,0,0,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      v = tv[i];
      @(negedge clk);
      drive(v.rst_n, v.iv, v.fl, v.ordy, v.mask, v.i0, v.pc0, v.i1, v.pc1);
      #2;
      if (v.chk)
        cmp_outs($sformatf("vec%0d", i), v.inr, v.o0v, v.o0pc, v.o0i, v.o1v, v.o1pc, v.o1i, v.rv, v.rpc);
`ifdef SCHED_PERF_CNT_EN
      if (i == 8) begin
        chk("perf_dual_after_t1t2", perf_dual_cnt, 32'd1);
        chk("perf_single_after_t1t2", perf_single_cnt, 32'd2);
      end
`endif
      @(posedge clk);
    end

    // Randomized phase against the queue model, starting from a reset.
    @(negedge clk);
    drive(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    @(posedge clk);
    mq.delete(); m_second = 0; m_redir = 0; m_rpc = 0; m_dual = 0; m_single = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r    = ($urandom_range(0, 99) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) < (((c / 200) % 2) != 0 ? 1 : 3));
      case ($urandom_range(0, 5))
        0:       m = 2'b00;
        1, 2:    m = 2'b01;
        default: m = 2'b11;
      endcase
      i0  = rnd_instr();
      i1  = rnd_instr();
      pc0 = $urandom & 32'hFFFF_FFFC;
      drive(r, iv, fl, ordy, m, i0, pc0, i1, pc0 + 32'd4);
      #2;
      model_eval();
      cmp_outs($sformatf("rnd%0d", c), e_inr, e_o0v, e_o0pc, e_o0i, e_o1v, e_o1pc, e_o1i, e_rv, e_rpc);
`ifdef SCHED_PERF_CNT_EN
      chk($sformatf("rnd%0d.perf_dual", c), perf_dual_cnt, m_dual);
      chk($sformatf("rnd%0d.perf_single", c), perf_single_cnt, m_single);
`endif
      @(posedge clk);
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
